pp_buf_ctrl: RTL

PP_BUF_CTRL -- requirements
Module: pp_buf_ctrl

---
 rtl/pp_buf_pkg.sv | 23 ++
 rtl/pp_buf_ctrl_bank_fsm.sv | 46 ++++
 rtl/pp_buf_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/pp_buf_pkg.sv
// Shared types and defaults for the ping-pong buffer controller.
// Holds the per-bank state enum and default geometry constants.
package pp_buf_pkg;

  typedef enum logic [1:0] {
    BK_EMPTY    = 2'd0,
    BK_FILLING  = 2'd1,
    BK_FULL     = 2'd2,
    BK_DRAINING = 2'd3
  } bank_st_e;

  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_BLK_LEN    = 4;

  function automatic logic st_wr_ok(bank_st_e s);
    return (s == BK_EMPTY) || (s == BK_FILLING);
  endfunction

  function automatic logic st_rd_ok(bank_st_e s);
    return (s == BK_FULL) || (s == BK_DRAINING);
  endfunction

endpackage

// File: rtl/pp_buf_ctrl_bank_fsm.sv
// One bank's lifecycle: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
// Ports: clk, rst_n, flush_i, wr_i/wr_last_i, rd_i/rd_last_i, state_o.
module pp_bank_fsm
  import pp_buf_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     flush_i,
  input  logic     wr_i,
  input  logic     wr_last_i,
  input  logic     rd_i,
  input  logic     rd_last_i,
  output bank_st_e state_o
);

  bank_st_e state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= BK_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = BK_EMPTY;
    end else begin
      unique case (state_q)
        BK_EMPTY:
          if (wr_i) state_d = BK_FILLING;
        BK_FILLING:
          if (wr_i && wr_last_i)
            state_d = BK_FULL;
        BK_FULL:
          if (rd_i) state_d = BK_DRAINING;
        BK_DRAINING:
          if (rd_i && rd_last_i)
            state_d = BK_EMPTY;
        default: state_d = BK_EMPTY;
      endcase
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/pp_buf_ctrl.sv
// Ping-pong buffer controller: two banks, write/read roles alternate.
// Optional sticky protocol error via macro PP_BUF_CTRL_ERR_EN.
module pp_buf_ctrl
  import pp_buf_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int BLK_LEN    = DEF_BLK_LEN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_req,
  output logic                  wr_rdy,
  input  logic                  rd_req,
  output logic                  rd_rdy,
  output logic                  rd_vld,
  output logic                  u0_wr,
  output logic                  u1_wr,
  output logic                  u0_rd,
  output logic                  u1_rd,
  output logic                  ena,
  output logic                  enb,
  output logic [ADDR_WIDTH-1:0] addra,
  output logic [ADDR_WIDTH-1:0] addrb,
  output logic                  blk_wr_done,
  output logic                  blk_rd_done,
  output logic                  err,
  input  logic                  err_clr
);

  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(BLK_LEN - 1);

  logic                  wbank_q, wbank_d;
  logic                  rbank_q, rbank_d;
  logic [ADDR_WIDTH-1:0] wcnt_q, wcnt_d;
  logic [ADDR_WIDTH-1:0] rcnt_q, rcnt_d;
  logic                  vld_q, vld_d;
  logic                  wdone_q, wdone_d;
  logic                  rdone_q, rdone_d;

  bank_st_e st0, st1, st_w, st_r;
  logic     wr_acc, rd_acc;
  logic     wr_last, rd_last;

  assign st_w = wbank_q ? st1 : st0;
  assign st_r = rbank_q ? st1 : st0;

  assign wr_rdy = st_wr_ok(st_w);
  assign rd_rdy = st_rd_ok(st_r);

  assign ena = wr_req & wr_rdy;
  assign enb = rd_req & rd_rdy;

  // flush wins over any request issued alongside it
  assign wr_acc  = ena & ~flush;
  assign rd_acc  = enb & ~flush;
  assign wr_last = (wcnt_q == LAST);
  assign rd_last = (rcnt_q == LAST);

  assign u0_wr = ~wbank_q & wr_rdy;
  assign u1_wr =  wbank_q & wr_rdy;
  assign u0_rd = ~rbank_q & rd_rdy;
  assign u1_rd =  rbank_q & rd_rdy;

  pp_bank_fsm u_bank0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush_i  (flush),
    .wr_i     (wr_acc & ~wbank_q),
    .wr_last_i(wr_last),
    .rd_i     (rd_acc & ~rbank_q),
    .rd_last_i(rd_last),
    .state_o  (st0)
  );

  pp_bank_fsm u_bank1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush_i  (flush),
    .wr_i     (wr_acc & wbank_q),
    .wr_last_i(wr_last),
    .rd_i     (rd_acc & rbank_q),
    .rd_last_i(rd_last),
    .state_o  (st1)
  );

  always_comb begin
    wbank_d = wbank_q;
    rbank_d = rbank_q;
    wcnt_d  = wcnt_q;
    rcnt_d  = rcnt_q;
    wdone_d = wr_acc & wr_last;
    rdone_d = rd_acc & rd_last;
    vld_d   = rd_acc;
    if (wr_acc) begin
      wcnt_d = wr_last ? '0 : wcnt_q + 1'b1;
      if (wr_last) wbank_d = ~wbank_q;
    end
    if (rd_acc) begin
      rcnt_d = rd_last ? '0 : rcnt_q + 1'b1;
      if (rd_last) rbank_d = ~rbank_q;
    end
    if (flush) begin
      wbank_d = 1'b0;
      rbank_d = 1'b0;
      wcnt_d  = '0;
      rcnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbank_q <= 1'b0;
      rbank_q <= 1'b0;
      wcnt_q  <= '0;
      rcnt_q  <= '0;
      vld_q   <= 1'b0;
      wdone_q <= 1'b0;
      rdone_q <= 1'b0;
    end else begin
      wbank_q <= wbank_d;
      rbank_q <= rbank_d;
      wcnt_q  <= wcnt_d;
      rcnt_q  <= rcnt_d;
      vld_q   <= vld_d;
      wdone_q <= wdone_d;
      rdone_q <= rdone_d;
    end
  end

  assign addra       = wcnt_q;
  assign addrb       = rcnt_q;
  assign rd_vld      = vld_q;
  assign blk_wr_done = wdone_q;
  assign blk_rd_done = rdone_q;

`ifdef PP_BUF_CTRL_ERR_EN
  logic err_q, err_d;
  logic viol;

  assign viol = (wr_req & ~wr_rdy) |
                (rd_req & ~rd_rdy);

  always_comb begin
    err_d = err_q;
    if (viol)         err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err = 1'b0;
`endif

endmodule
